// File: rtl/sdram_cpu_port.sv
// sdram_cpu_port
//   Sits between the CPU/two-way cache and one SDRAM controller port.
//   - Cache line fills become critical-word-first 4-word burst reads. Fill data
//     returns on cache_data with a one-cycle cache_fill strobe on the first word.
//   - CPU write-through traffic goes into a small write-merging FIFO. The FIFO
//     drains to SDRAM one word at a time whenever no fill is pending.
//   - A fill whose line still has buffered writes drains the buffer first, so a
//     read never overtakes an older write to the same cacheline.
// Ports
//   clk, reset_n                  clock, synchronous active-low reset
//   cpu_addr/req/rw_n/rwl_n/rwu_n CPU request; only writes (rw_n=0) are handled
//   data_from_cpu                 write data
//   cpu_wr_ack                    one-cycle pulse when a write is accepted
//   wb_full                       registered buffer-full flag
//   cache_req                     line-fill request (level)
//   cache_fill, cache_data        fill strobe (first word only) and fill data
//   sd_req/ack/we/addr/dqm/wdata  SDRAM transaction request, held until sd_ack
//   sd_rdata, sd_rvalid           burst read data (4 consecutive words)
module sdram_cpu_port #(
  parameter int unsigned WB_DEPTH  = 4,
  parameter int unsigned ADDR_BITS = 26
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [31:0]          cpu_addr,
  input  logic                 cpu_req,
  input  logic                 cpu_rw_n,
  input  logic                 cpu_rwl_n,
  input  logic                 cpu_rwu_n,
  input  logic [15:0]          data_from_cpu,
  output logic                 cpu_wr_ack,
  output logic                 wb_full,
  input  logic                 cache_req,
  output logic                 cache_fill,
  output logic [15:0]          cache_data,
  output logic                 sd_req,
  input  logic                 sd_ack,
  output logic                 sd_we,
  output logic [ADDR_BITS-2:0] sd_addr,
  output logic [1:0]           sd_dqm,
  output logic [15:0]          sd_wdata,
  input  logic [15:0]          sd_rdata,
  input  logic                 sd_rvalid
);

  localparam int unsigned PtrW = $clog2(WB_DEPTH);
  localparam int unsigned CntW = $clog2(WB_DEPTH + 1);
  localparam int unsigned WaW  = ADDR_BITS - 1;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_WR_ISSUE = 2'd1;
  localparam logic [1:0] ST_RD_ISSUE = 2'd2;
  localparam logic [1:0] ST_RD_DATA  = 2'd3;

  // Write buffer storage
  logic [WaW-1:0]  r_wb_addr [WB_DEPTH];
  logic [1:0]      r_wb_dqm  [WB_DEPTH];
  logic [15:0]     r_wb_data [WB_DEPTH];
  logic [PtrW-1:0] r_head;
  logic [PtrW-1:0] r_tail;
  logic [CntW-1:0] r_count;

  logic [1:0]      r_state;
  logic [1:0]      r_rcnt;
  logic            r_acc;
  logic            r_wb_full;
  logic            r_cpu_wr_ack;
  logic            r_cache_fill;
  logic [15:0]     r_cache_data;
  logic            r_sd_req;
  logic            r_sd_we;
  logic [WaW-1:0]  r_sd_addr;
  logic [1:0]      r_sd_dqm;
  logic [15:0]     r_sd_wdata;

  logic            w_wr_req;
  logic [1:0]      w_wr_dqm;
  logic [WaW-1:0]  w_wr_waddr;
  logic            w_no_bytes;
  logic            w_full;
  logic [PtrW-1:0] w_tail_idx;
  logic            w_tail_busy;
  logic            w_merge;
  logic            w_push;
  logic            w_pop;
  logic            w_accept;
  logic            w_line_hit;
  logic [PtrW-1:0] w_off;
  logic            w_start_wr;
  logic            w_start_rd;
  logic [CntW-1:0] w_count_d;
  logic            w_unused;

  assign w_unused   = ^{cpu_addr[31:ADDR_BITS], cpu_addr[0]};

  // A write is only taken once per cpu_req assertion.
  assign w_wr_req   = cpu_req & ~cpu_rw_n & ~r_acc;
  assign w_wr_dqm   = {cpu_rwu_n, cpu_rwl_n};
  assign w_wr_waddr = cpu_addr[ADDR_BITS-1:1];
  // A write with no byte enabled is acknowledged but never stored, so an
  // all-masked SDRAM write can never be issued.
  assign w_no_bytes = &w_wr_dqm;
  assign w_full     = (r_count == CntW'(WB_DEPTH));
  assign w_tail_idx = r_tail - PtrW'(1);

  // The tail must not change once it has been (or is being) copied to sd_*.
  assign w_tail_busy = (w_tail_idx == r_head) && ((r_state == ST_WR_ISSUE) || w_start_wr);
  assign w_merge  = w_wr_req && !w_no_bytes && (r_count != '0) &&
                    (r_wb_addr[w_tail_idx] == w_wr_waddr) && !w_tail_busy;
  // Full refuses a push even when the head pops in the same cycle.
  assign w_push   = w_wr_req && !w_no_bytes && !w_merge && !w_full;
  assign w_accept = w_merge || w_push || (w_wr_req && w_no_bytes);
  assign w_pop    = (r_state == ST_WR_ISSUE) && sd_ack;

  always_comb begin
    w_count_d = r_count;
    if (w_push && !w_pop) begin
      w_count_d = r_count + CntW'(1);
    end else if (!w_push && w_pop) begin
      w_count_d = r_count - CntW'(1);
    end
  end

  // Any live entry in the same cacheline as the requested fill.
  always_comb begin
    w_line_hit = 1'b0;
    w_off      = '0;
    for (int i = 0; i < int'(WB_DEPTH); i++) begin
      w_off = PtrW'(i) - r_head;
      if (({1'b0, w_off} < r_count) &&
          (r_wb_addr[i][WaW-1:2] == cpu_addr[ADDR_BITS-1:3])) begin
        w_line_hit = 1'b1;
      end
    end
  end

  // Fill wins unless its line is still buffered; then the FIFO drains in order.
  assign w_start_wr = (r_state == ST_IDLE) && (r_count != '0) && (!cache_req || w_line_hit);
  assign w_start_rd = (r_state == ST_IDLE) && cache_req && !w_line_hit;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_wb_addr[r_tail] <= w_wr_waddr;
      r_wb_dqm[r_tail]  <= w_wr_dqm;
      r_wb_data[r_tail] <= data_from_cpu;
    end else if (w_merge) begin
      if (!cpu_rwl_n) r_wb_data[w_tail_idx][7:0]  <= data_from_cpu[7:0];
      if (!cpu_rwu_n) r_wb_data[w_tail_idx][15:8] <= data_from_cpu[15:8];
      r_wb_dqm[w_tail_idx] <= r_wb_dqm[w_tail_idx] & w_wr_dqm;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state      <= ST_IDLE;
      r_head       <= '0;
      r_tail       <= '0;
      r_count      <= '0;
      r_rcnt       <= '0;
      r_acc        <= 1'b0;
      r_wb_full    <= 1'b0;
      r_cpu_wr_ack <= 1'b0;
      r_cache_fill <= 1'b0;
      r_cache_data <= '0;
      r_sd_req     <= 1'b0;
      r_sd_we      <= 1'b0;
      r_sd_addr    <= '0;
      r_sd_dqm     <= 2'b11;
      r_sd_wdata   <= '0;
    end else begin
      r_cpu_wr_ack <= w_accept;
      r_acc        <= cpu_req & (r_acc | w_accept);
      if (w_push) r_tail <= r_tail + PtrW'(1);
      if (w_pop)  r_head <= r_head + PtrW'(1);
      r_count      <= w_count_d;
      r_wb_full    <= (w_count_d == CntW'(WB_DEPTH));
      r_cache_fill <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          if (w_start_wr) begin
            r_sd_req   <= 1'b1;
            r_sd_we    <= 1'b1;
            r_sd_addr  <= r_wb_addr[r_head];
            r_sd_dqm   <= r_wb_dqm[r_head];
            r_sd_wdata <= r_wb_data[r_head];
            r_state    <= ST_WR_ISSUE;
          end else if (w_start_rd) begin
            // Critical word first: the controller wraps within the line.
            r_sd_req   <= 1'b1;
            r_sd_we    <= 1'b0;
            r_sd_addr  <= cpu_addr[ADDR_BITS-1:1];
            r_sd_dqm   <= 2'b00;
            r_state    <= ST_RD_ISSUE;
          end
        end
        ST_WR_ISSUE: begin
          if (sd_ack) begin
            r_sd_req <= 1'b0;
            r_state  <= ST_IDLE;
          end
        end
        ST_RD_ISSUE: begin
          if (sd_ack) begin
            r_sd_req <= 1'b0;
            r_rcnt   <= '0;
            r_state  <= ST_RD_DATA;
          end
        end
        ST_RD_DATA: begin
          if (sd_rvalid) begin
            r_cache_data <= sd_rdata;
            r_cache_fill <= (r_rcnt == 2'd0);
            r_rcnt       <= r_rcnt + 2'd1;
            if (r_rcnt == 2'd3) r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign cpu_wr_ack = r_cpu_wr_ack;
  assign wb_full    = r_wb_full;
  assign cache_fill = r_cache_fill;
  assign cache_data = r_cache_data;
  assign sd_req     = r_sd_req;
  assign sd_we      = r_sd_we;
  assign sd_addr    = r_sd_addr;
  assign sd_dqm     = r_sd_dqm;
  assign sd_wdata   = r_sd_wdata;

endmodule

// File: tb/tb_sdram_cpu_port.sv
// Self-checking bench for sdram_cpu_port: single-write vector table, hand-built
// merge / fill / ordering / full / reset sequences, then randomized traffic
// against a memory-image model of the SDRAM.
module tb_sdram_cpu_port;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] cpu_addr;
  logic        cpu_req;
  logic        cpu_rw_n;
  logic        cpu_rwl_n;
  logic        cpu_rwu_n;
  logic [15:0] data_from_cpu;
  logic        cpu_wr_ack;
  logic        wb_full;
  logic        cache_req;
  logic        cache_fill;
  logic [15:0] cache_data;
  logic        sd_req;
  logic        sd_ack;
  logic        sd_we;
  logic [24:0] sd_addr;
  logic [1:0]  sd_dqm;
  logic [15:0] sd_wdata;
  logic [15:0] sd_rdata;
  logic        sd_rvalid;

  always #5 clk = ~clk;

  sdram_cpu_port dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .cpu_addr     (cpu_addr),
    .cpu_req      (cpu_req),
    .cpu_rw_n     (cpu_rw_n),
    .cpu_rwl_n    (cpu_rwl_n),
    .cpu_rwu_n    (cpu_rwu_n),
    .data_from_cpu(data_from_cpu),
    .cpu_wr_ack   (cpu_wr_ack),
    .wb_full      (wb_full),
    .cache_req    (cache_req),
    .cache_fill   (cache_fill),
    .cache_data   (cache_data),
    .sd_req       (sd_req),
    .sd_ack       (sd_ack),
    .sd_we        (sd_we),
    .sd_addr      (sd_addr),
    .sd_dqm       (sd_dqm),
    .sd_wdata     (sd_wdata),
    .sd_rdata     (sd_rdata),
    .sd_rvalid    (sd_rvalid)
  );

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic [31:0] addr;
    logic        rwl_n;
    logic        rwu_n;
    logic [15:0] data;
    logic [24:0] exp_addr;
    logic [1:0]  exp_dqm;
  } wvec_t;

  wvec_t vecs [5];

  // Reference model: SDRAM image seen by the bench, and the image implied by
  // every acknowledged CPU write applied in program order.
  logic [15:0] mem    [64];
  logic [15:0] shadow [64];
  int          burst_left;
  logic [3:0]  burst_line;
  logic [1:0]  burst_w;
  logic [15:0] exp_fill [4];
  int          fill_idx;
  int          fills_seen;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ack();
    sd_ack = 1'b1;
    tick();
    sd_ack = 1'b0;
  endtask

  task automatic wait_req(input string name);
    int n = 0;
    while (!sd_req && n < 50) begin
      tick();
      n++;
    end
    chk({name, " sd_req"}, sd_req, 1);
  endtask

  task automatic check_reset(input string name);
    chk({name, " sd_req"},     sd_req,     0);
    chk({name, " sd_we"},      sd_we,      0);
    chk({name, " cache_fill"}, cache_fill, 0);
    chk({name, " cpu_wr_ack"}, cpu_wr_ack, 0);
    chk({name, " cache_data"}, cache_data, 0);
    chk({name, " sd_addr"},    sd_addr,    0);
    chk({name, " sd_dqm"},     sd_dqm,     2'b11);
    chk({name, " sd_wdata"},   sd_wdata,   0);
    chk({name, " wb_full"},    wb_full,    0);
  endtask

  task automatic hand_write(input logic [31:0] a, input logic rwl, input logic rwu,
                            input logic [15:0] d, input string name);
    cpu_addr      = a;
    cpu_rw_n      = 1'b0;
    cpu_rwl_n     = rwl;
    cpu_rwu_n     = rwu;
    data_from_cpu = d;
    cpu_req       = 1'b1;
    tick();
    chk({name, " ack"}, cpu_wr_ack, 1);
    cpu_req  = 1'b0;
    cpu_rw_n = 1'b1;
    tick();
    chk({name, " ack pulse"}, cpu_wr_ack, 0);
  endtask

  // One clock of random traffic: fill-data monitor plus an SDRAM responder.
  task automatic rcycle();
    tick();
    if (cache_fill) begin
      chk("rnd fill word0", cache_data, exp_fill[0]);
      fill_idx = 1;
      fills_seen++;
    end else if (fill_idx > 0 && fill_idx < 4) begin
      chk("rnd fill word", cache_data, exp_fill[fill_idx]);
      fill_idx++;
    end
    sd_ack    = 1'b0;
    sd_rvalid = 1'b0;
    if (burst_left > 0) begin
      sd_rvalid = 1'b1;
      sd_rdata  = mem[{burst_line, burst_w}];
      burst_w++;
      burst_left--;
    end else if (sd_req && $urandom_range(0, 2) == 0) begin
      sd_ack = 1'b1;
      if (sd_we) begin
        chk("rnd wr dqm not 11", sd_dqm != 2'b11, 1);
        if (!sd_dqm[0]) mem[sd_addr[5:0]][7:0]  = sd_wdata[7:0];
        if (!sd_dqm[1]) mem[sd_addr[5:0]][15:8] = sd_wdata[15:8];
      end else begin
        burst_left = 4;
        burst_line = sd_addr[5:2];
        burst_w    = sd_addr[1:0];
      end
    end
  endtask

  initial begin
    logic [15:0] fw [4];
    logic        got;
    logic [5:0]  waddr;
    logic [5:0]  last_waddr;
    logic        was_full;
    int          n;
    int          bsel;
    int          seen0;
    logic [1:0]  wi;

    reset_n       = 1'b0;
    cpu_addr      = '0;
    cpu_req       = 1'b0;
    cpu_rw_n      = 1'b1;
    cpu_rwl_n     = 1'b1;
    cpu_rwu_n     = 1'b1;
    data_from_cpu = '0;
    cache_req     = 1'b0;
    sd_ack        = 1'b0;
    sd_rdata      = '0;
    sd_rvalid     = 1'b0;
    repeat (3) tick();
    check_reset("reset");
    reset_n = 1'b1;
    tick();

    // Single writes: address bit 0 and bits above ADDR_BITS dropped, dqm = {rwu_n, rwl_n}
    vecs[0] = '{32'h0000_0100, 1'b0, 1'b0, 16'hBEEF, 25'h000_0080, 2'b00};
    vecs[1] = '{32'h0000_0101, 1'b0, 1'b1, 16'h1234, 25'h000_0080, 2'b10};
    vecs[2] = '{32'h03FF_FFFE, 1'b1, 1'b0, 16'h5AA5, 25'h1FF_FFFF, 2'b01};
    vecs[3] = '{32'hFC00_0002, 1'b0, 1'b0, 16'hA5A5, 25'h000_0001, 2'b00};
    vecs[4] = '{32'h0000_0000, 1'b0, 1'b0, 16'h0000, 25'h000_0000, 2'b00};
    for (int v = 0; v < 5; v++) begin
      hand_write(vecs[v].addr, vecs[v].rwl_n, vecs[v].rwu_n, vecs[v].data, "vec");
      wait_req("vec");
      chk("vec sd_we",    sd_we,    1);
      chk("vec sd_addr",  sd_addr,  vecs[v].exp_addr);
      chk("vec sd_dqm",   sd_dqm,   vecs[v].exp_dqm);
      chk("vec sd_wdata", sd_wdata, vecs[v].data);
      ack();
      chk("vec req drop", sd_req, 0);
      repeat (3) tick();
      chk("vec empty", sd_req, 0);
      chk("vec wb_full", wb_full, 0);
    end

    // Merge behind a busy head
    hand_write(32'h100, 1'b0, 1'b0, 16'h1111, "m0");
    wait_req("m0");
    hand_write(32'h200, 1'b0, 1'b1, 16'hAB34, "m1");
    hand_write(32'h200, 1'b1, 1'b0, 16'h12CD, "m2");
    chk("merge head addr", sd_addr, 25'h80);
    ack();
    wait_req("merge");
    chk("merge sd_we",    sd_we,    1);
    chk("merge sd_addr",  sd_addr,  25'h100);
    chk("merge sd_dqm",   sd_dqm,   2'b00);
    chk("merge sd_wdata", sd_wdata, 16'h1234);
    ack();
    repeat (5) tick();
    chk("merge single write", sd_req, 0);

    // Critical-word-first fill
    fw = '{16'hA001, 16'hB002, 16'hC003, 16'hD004};
    cpu_addr  = 32'h406;
    cache_req = 1'b1;
    tick();
    wait_req("fill");
    chk("fill sd_we",   sd_we,   0);
    chk("fill sd_addr", sd_addr, 25'h203);
    ack();
    for (int k = 0; k < 4; k++) begin
      sd_rvalid = 1'b1;
      sd_rdata  = fw[k];
      tick();
      chk("fill data", cache_data, fw[k]);
      chk("fill strobe", cache_fill, (k == 0));
      if (k == 0) cache_req = 1'b0;
    end
    sd_rvalid = 1'b0;
    tick();
    chk("fill strobe end", cache_fill, 0);
    repeat (4) tick();
    chk("fill no reissue", sd_req, 0);

    // Read-after-write within a line
    cpu_addr      = 32'h408;
    cpu_rw_n      = 1'b0;
    cpu_rwl_n     = 1'b0;
    cpu_rwu_n     = 1'b0;
    data_from_cpu = 16'h5555;
    cpu_req       = 1'b1;
    tick();
    chk("raw ack", cpu_wr_ack, 1);
    cpu_req   = 1'b0;
    cpu_rw_n  = 1'b1;
    cpu_addr  = 32'h40C;
    cache_req = 1'b1;
    tick();
    wait_req("raw wr");
    chk("raw first is write", sd_we,   1);
    chk("raw wr addr",        sd_addr, 25'h204);
    repeat (3) tick();
    chk("raw wr held", sd_we & sd_req, 1);
    ack();
    wait_req("raw rd");
    chk("raw rd sd_we",   sd_we,   0);
    chk("raw rd sd_addr", sd_addr, 25'h206);
    ack();
    got = 1'b0;
    for (int k = 0; k < 4; k++) begin
      sd_rvalid = 1'b1;
      sd_rdata  = 16'h7000 + 16'(k);
      tick();
      if (cache_fill) got = 1'b1;
      cache_req = 1'b0;
    end
    sd_rvalid = 1'b0;
    chk("raw fill", got, 1);
    chk("raw last word", cache_data, 16'h7003);
    tick();

    // Full buffer
    for (int i = 0; i < 4; i++) begin
      hand_write(32'h1000 + 32'(2 * i), 1'b0, 1'b0, 16'h0F00 + 16'(i), "full fill");
    end
    chk("full wb_full", wb_full, 1);
    cpu_addr      = 32'h1008;
    cpu_rw_n      = 1'b0;
    data_from_cpu = 16'h0F04;
    cpu_req       = 1'b1;
    got = 1'b0;
    repeat (5) begin
      tick();
      if (cpu_wr_ack) got = 1'b1;
    end
    chk("full no ack", got, 0);
    chk("full head", sd_addr, 25'h800);
    ack();
    chk("full refused on pop", cpu_wr_ack, 0);
    chk("full flag after pop", wb_full, 0);
    tick();
    chk("full late ack", cpu_wr_ack, 1);
    chk("full flag refilled", wb_full, 1);
    cpu_req  = 1'b0;
    cpu_rw_n = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      wait_req("full drain");
      chk("full drain we", sd_we, 1);
      chk("full drain addr", sd_addr, 25'h800 + 25'(i));
      ack();
    end
    tick();
    chk("full empty", wb_full, 0);

    // Randomized traffic against the memory-image model
    for (int i = 0; i < 64; i++) begin
      mem[i]    = 16'(i * 16'h0101) ^ 16'h5A5A;
      shadow[i] = mem[i];
    end
    burst_left = 0;
    fill_idx   = 0;
    fills_seen = 0;
    last_waddr = '0;
    for (int op = 0; op < 150; op++) begin
      n = $urandom_range(0, 9);
      if (n < 6) begin
        waddr = ($urandom_range(0, 2) == 0) ? last_waddr : 6'($urandom_range(0, 63));
        last_waddr = waddr;
        bsel  = $urandom_range(0, 2);
        cpu_addr      = {25'd0, waddr, 1'b0};
        cpu_rw_n      = 1'b0;
        cpu_rwl_n     = (bsel == 2);
        cpu_rwu_n     = (bsel == 1);
        data_from_cpu = 16'($urandom);
        was_full      = wb_full;
        cpu_req       = 1'b1;
        got = 1'b0;
        n   = 0;
        while (!got && n < 200) begin
          rcycle();
          n++;
          if (cpu_wr_ack) got = 1'b1;
        end
        chk("rnd wr ack", got, 1);
        if (!was_full) chk("rnd wr ack latency", n, 1);
        if (got) begin
          if (!cpu_rwl_n) shadow[waddr][7:0]  = data_from_cpu[7:0];
          if (!cpu_rwu_n) shadow[waddr][15:8] = data_from_cpu[15:8];
        end
        cpu_req  = 1'b0;
        cpu_rw_n = 1'b1;
        rcycle();
      end else if (n < 8) begin
        waddr    = 6'($urandom_range(0, 63));
        cpu_addr = {25'd0, waddr, 1'b0};
        for (int k = 0; k < 4; k++) begin
          wi = waddr[1:0] + 2'(k);
          exp_fill[k] = shadow[{waddr[5:2], wi}];
        end
        fill_idx  = 0;
        seen0     = fills_seen;
        cache_req = 1'b1;
        n = 0;
        while (fills_seen == seen0 && n < 300) begin
          rcycle();
          n++;
        end
        cache_req = 1'b0;
        chk("rnd fill seen", fills_seen - seen0, 1);
        repeat (4) rcycle();
      end else begin
        repeat ($urandom_range(1, 3)) rcycle();
      end
    end
    repeat (60) rcycle();
    chk("rnd drained", sd_req, 0);
    for (int i = 0; i < 64; i++) begin
      chk("rnd mem image", mem[i], shadow[i]);
    end
    sd_ack    = 1'b0;
    sd_rvalid = 1'b0;
    tick();

    // Reset in the middle of a burst
    cpu_addr  = 32'h800;
    cache_req = 1'b1;
    tick();
    wait_req("rst fill");
    ack();
    for (int k = 0; k < 2; k++) begin
      sd_rvalid = 1'b1;
      sd_rdata  = 16'hE000 + 16'(k);
      tick();
    end
    chk("rst pre data", cache_data, 16'hE001);
    reset_n   = 1'b0;
    cache_req = 1'b0;
    sd_rdata  = 16'hE002;
    tick();
    check_reset("rst mid");
    reset_n  = 1'b1;
    sd_rdata = 16'hE003;
    tick();
    chk("rst stale fill", cache_fill, 0);
    chk("rst stale data", cache_data, 0);
    sd_rvalid = 1'b0;
    tick();
    chk("rst idle", sd_req, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
